// File: rtl/demux_tdm4_if.sv
// Signal bundle between a TDM source and the 4-slot demultiplexer.
// The demux sits on the slave side; the stream producer and the channel consumers sit on the master side.
interface demux_tdm4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic [WIDTH-1:0] o3;
    logic             frame_valid;
    logic             sync_err;
    logic             locked;
    logic [1:0]       slot;

    modport master (
        output din, din_valid, frame_sync,
        input  o0, o1, o2, o3, frame_valid, sync_err, locked, slot
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output o0, o1, o2, o3, frame_valid, sync_err, locked, slot
    );
endinterface

// File: rtl/demux_tdm4.sv
// Four-slot TDM demultiplexer: locks onto frame_sync and publishes each completed frame on o0..o3.
//   state  | meaning
//   HUNT   | unsynchronised; beats are dropped until one arrives with frame_sync=1
//   LOCKED | aligned; beats fill slots 0..3, and slot 3 publishes the frame
module demux_tdm4 #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    demux_tdm4_if.slave  bus
);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, state_nx;
    logic [1:0]       slot_q, slot_nx;
    logic [WIDTH-1:0] sh0, sh1, sh2, sh0_nx, sh1_nx, sh2_nx;
    logic [WIDTH-1:0] o0_q, o1_q, o2_q, o3_q;
    logic [WIDTH-1:0] o0_nx, o1_nx, o2_nx, o3_nx;
    logic             fv_q, fv_nx, se_q, se_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HUNT;
            slot_q <= '0;
            sh0    <= '0;
            sh1    <= '0;
            sh2    <= '0;
            o0_q   <= '0;
            o1_q   <= '0;
            o2_q   <= '0;
            o3_q   <= '0;
            fv_q   <= 1'b0;
            se_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            slot_q <= slot_nx;
            sh0    <= sh0_nx;
            sh1    <= sh1_nx;
            sh2    <= sh2_nx;
            o0_q   <= o0_nx;
            o1_q   <= o1_nx;
            o2_q   <= o2_nx;
            o3_q   <= o3_nx;
            fv_q   <= fv_nx;
            se_q   <= se_nx;
        end
    end

    always_comb begin
        state_nx = state;
        slot_nx  = slot_q;
        sh0_nx   = sh0;
        sh1_nx   = sh1;
        sh2_nx   = sh2;
        o0_nx    = o0_q;
        o1_nx    = o1_q;
        o2_nx    = o2_q;
        o3_nx    = o3_q;
        fv_nx    = 1'b0;
        se_nx    = 1'b0;
        if (bus.din_valid) begin
            unique case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        sh0_nx   = bus.din;
                        slot_nx  = 2'd1;
                        state_nx = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (bus.frame_sync) begin
                            sh0_nx  = bus.din;
                            slot_nx = 2'd1;
                        end else begin
                            se_nx    = 1'b1;
                            slot_nx  = 2'd0;
                            state_nx = HUNT;
                        end
                    end else if (bus.frame_sync) begin
                        // Early sync: drop the partial frame and restart at slot 0 with this beat.
                        se_nx   = 1'b1;
                        sh0_nx  = bus.din;
                        slot_nx = 2'd1;
                    end else begin
                        unique case (slot_q)
                            2'd1: sh1_nx = bus.din;
                            2'd2: sh2_nx = bus.din;
                            default: begin
                                // Slot 3 bypasses the shadow so the frame publishes on this edge.
                                o0_nx = sh0;
                                o1_nx = sh1;
                                o2_nx = sh2;
                                o3_nx = bus.din;
                                fv_nx = 1'b1;
                            end
                        endcase
                        slot_nx = slot_q + 2'd1;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end
    end

    assign bus.o0          = o0_q;
    assign bus.o1          = o1_q;
    assign bus.o2          = o2_q;
    assign bus.o3          = o3_q;
    assign bus.frame_valid = fv_q;
    assign bus.sync_err    = se_q;
    assign bus.locked      = (state == LOCKED);
    assign bus.slot        = slot_q;
endmodule

// File: tb/tb_demux_tdm4.sv
// Bench for demux_tdm4: directed beats, with a scoreboard queue of expected frame/sync_err pulses.
// A monitor compares those pulses against the queue; the stimulus thread checks locked, slot and the held outputs.
module tb_demux_tdm4;
    localparam int W = 4;

    typedef struct {
        bit          is_frame;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    demux_tdm4_if #(.WIDTH(W)) bus ();

    demux_tdm4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.o0, bus.o1, bus.o2, bus.o3};
    endfunction

    task automatic push_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d);
        exp_t e;
        e.is_frame = 1'b1;
        e.data     = {a, b, c, d};
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_frame = 1'b0;
        e.data     = '0;
        sb.push_back(e);
    endtask

    task automatic beat(input logic fs, input logic [3:0] d);
        @(negedge clk);
        bus.din_valid  = 1'b1;
        bus.frame_sync = fs;
        bus.din        = d;
        @(posedge clk);
        #1;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b1;
        bus.din        = 4'hF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every pulse must match the head of the expected queue.
    always @(posedge clk) begin
        #1;
        if (bus.frame_valid || bus.sync_err) begin
            checks++;
            if (bus.frame_valid && bus.sync_err) begin
                failures++;
                $display("FAIL pulse_overlap: frame_valid and sync_err both high at %0t", $time);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: frame_valid=%0b sync_err=%0b with nothing expected at %0t",
                         bus.frame_valid, bus.sync_err, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_frame !== bus.frame_valid) begin
                    failures++;
                    $display("FAIL pulse_kind: frame_valid=%0b expected %0b at %0t",
                             bus.frame_valid, e.is_frame, $time);
                end else if (e.is_frame && (outs() !== e.data)) begin
                    failures++;
                    $display("FAIL frame_data: got %04h expected %04h at %0t", outs(), e.data, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        #12;
        chk("reset_outs", outs(), 16'h0000);
        chk("reset_locked", bus.locked, 0);
        chk("reset_slot", bus.slot, 0);
        chk("reset_pulses", {bus.frame_valid, bus.sync_err}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Hunt: non-sync beats are dropped.
        for (int i = 0; i < 10; i++) beat(1'b0, 4'(i));
        chk("hunt_slot", bus.slot, 0);
        chk("hunt_locked", bus.locked, 0);

        // First frame, 1-bit pattern.
        beat(1'b1, 4'h1);
        chk("lock_slot", bus.slot, 1);
        chk("lock_locked", bus.locked, 1);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h1);
        push_frame(4'h1, 4'h0, 4'h1, 4'h1);
        beat(1'b0, 4'h1);
        chk("f1_locked", bus.locked, 1);
        chk("f1_slot", bus.slot, 0);
        chk("f1_outs", outs(), 16'h1011);
        idle(1);
        chk("f1_pulse_one_cycle", bus.frame_valid, 0);

        // Gapped beats: frame completes only on the fourth valid beat.
        beat(1'b1, 4'h1);
        idle(3);
        beat(1'b0, 4'h1);
        idle(3);
        beat(1'b0, 4'h0);
        idle(3);
        chk("gap_slot", bus.slot, 3);
        chk("gap_hold", outs(), 16'h1011);
        push_frame(4'h1, 4'h1, 4'h0, 4'h0);
        beat(1'b0, 4'h0);
        chk("gap_outs", outs(), 16'h1100);

        push_frame(4'hA, 4'hB, 4'hC, 4'hD);
        beat(1'b1, 4'hA);
        beat(1'b0, 4'hB);
        beat(1'b0, 4'hC);
        beat(1'b0, 4'hD);

        // Sync on slot 2.
        beat(1'b1, 4'h5);
        beat(1'b0, 4'h6);
        push_err();
        beat(1'b1, 4'h7);
        chk("s2_slot", bus.slot, 1);
        chk("s2_locked", bus.locked, 1);
        chk("s2_hold", outs(), 16'hABCD);
        push_frame(4'h7, 4'h8, 4'h9, 4'hE);
        beat(1'b0, 4'h8);
        beat(1'b0, 4'h9);
        beat(1'b0, 4'hE);

        // Sync on slot 3.
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h2);
        beat(1'b0, 4'h3);
        push_err();
        beat(1'b1, 4'h4);
        chk("s3_slot", bus.slot, 1);
        chk("s3_hold", outs(), 16'h789E);
        push_frame(4'h4, 4'h5, 4'h6, 4'h7);
        beat(1'b0, 4'h5);
        beat(1'b0, 4'h6);
        beat(1'b0, 4'h7);

        // Sync on slot 1.
        beat(1'b1, 4'h3);
        push_err();
        beat(1'b1, 4'h2);
        chk("s1_slot", bus.slot, 1);
        push_frame(4'h2, 4'h1, 4'h0, 4'hF);
        beat(1'b0, 4'h1);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'hF);

        // Missing sync at slot 0: back to hunt.
        push_err();
        beat(1'b0, 4'h3);
        chk("loss_locked", bus.locked, 0);
        chk("loss_slot", bus.slot, 0);
        beat(1'b0, 4'h4);
        beat(1'b0, 4'h5);
        beat(1'b0, 4'h6);
        chk("loss_ignored_slot", bus.slot, 0);
        chk("loss_hold", outs(), 16'h210F);
        beat(1'b1, 4'h9);
        chk("relock", bus.locked, 1);
        push_frame(4'h9, 4'h8, 4'h7, 4'h6);
        beat(1'b0, 4'h8);
        beat(1'b0, 4'h7);
        beat(1'b0, 4'h6);

        // Asynchronous reset mid-frame.
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outs", outs(), 16'h0000);
        chk("arst_locked", bus.locked, 0);
        chk("arst_slot", bus.slot, 0);
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        beat(1'b0, 4'h5);
        chk("post_rst_hunt_slot", bus.slot, 0);
        push_frame(4'h1, 4'h2, 4'h3, 4'h4);
        beat(1'b1, 4'h1);
        beat(1'b0, 4'h2);
        beat(1'b0, 4'h3);
        beat(1'b0, 4'h4);
        idle(3);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
